// File: rtl/demux1to4_buf.sv
// Registered 1-to-4 valid/ready demultiplexer with a one-entry buffer per channel.
// Each channel drains independently; a stalled channel only blocks words addressed to it.
module demux1to4_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             S0,
  input  logic             S1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  logic [1:0]       ch;
  logic             accept;
  logic [WIDTH-1:0] data_reg [4];
  logic [3:0]       valid_reg;

  assign ch = {S0, S1};

  // A full buffer can still take a word when its consumer empties it on the same edge.
  assign in_ready = ~rst & (~valid_reg[ch] | out_ready[ch]);
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic load;
      assign load = accept & (ch == 2'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (load) begin
          data_reg[gi]  <= in_data;
          valid_reg[gi] <= 1'b1;
        end else if (out_ready[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid = valid_reg;
  assign out_data0 = data_reg[0];
  assign out_data1 = data_reg[1];
  assign out_data2 = data_reg[2];
  assign out_data3 = data_reg[3];

endmodule

// File: tb/tb_demux1to4_buf.sv
// Scoreboard bench for demux1to4_buf: per-channel FIFO model of accepted words,
// directed scenarios followed by randomized traffic and random backpressure.
module tb_demux1to4_buf;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             S0, S1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;

  demux1to4_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .S0        (S0),
    .S1        (S1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit rand_ready = 0;

  logic [WIDTH-1:0] exp_q [4][$];
  logic [WIDTH-1:0] od [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the channel queues, then advances the model.
  always @(negedge clk) begin : monitor
    int sel;
    logic exp_ready;
    logic [WIDTH-1:0] w;
    if (started) begin
      sel = int'({S0, S1});
      exp_ready = !rst && (exp_q[sel].size() == 0 || out_ready[sel]);
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("occupancy%0d", k), 32'(exp_q[k].size() <= 1), 32'd1);
        chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
        if (exp_q[k].size() != 0)
          chk($sformatf("out_data%0d", k), 32'(od[k]), 32'(exp_q[k][0]));
      end
      if (rst) begin
        for (int k = 0; k < 4; k++) exp_q[k].delete();
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (exp_q[k].size() != 0 && out_ready[k]) begin
            w = exp_q[k].pop_front();
            $display("deliver ch%0d data %02h t=%0t", k, w, $time);
          end
        end
        if (in_valid && exp_ready) exp_q[sel].push_back(in_data);
      end
    end
  end

  task automatic drive(input int c, input logic [WIDTH-1:0] d);
    logic [1:0] s;
    s = 2'(c);
    S0 = s[1];
    S1 = s[0];
    in_data = d;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 4'($urandom);
    end
  endtask

  task automatic wait_accept(output int cyc);
    logic acc;
    cyc = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      cyc++;
      @(posedge clk); #1;
      if (acc) break;
      if (rand_ready) out_ready = 4'($urandom);
      if (cyc > 200) begin
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        break;
      end
    end
  endtask

  task automatic send(input int c, input logic [WIDTH-1:0] d);
    int cyc;
    drive(c, d);
    wait_accept(cyc);
  endtask

  initial begin : stim
    int cyc, total;
    logic [1:0] s;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; S0 = 1'b1; S1 = 1'b0; out_ready = 4'b1111;
    @(posedge clk); #1;
    started = 1;
    @(posedge clk); #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("reset_data%0d", k), 32'(od[k]), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k); S0 = s[1]; S1 = s[0]; #1;
      chk($sformatf("post_reset_ready%0d", k), 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;

    // Routing: one word per channel, consecutive cycles.
    for (int k = 0; k < 4; k++) send(k, 8'hA0 + 8'(k));
    idle(2);
    chk("routing_drained", 32'(out_valid), 32'd0);

    // Backpressure on ch2: 66 waits behind 55, then replaces it on the draining edge.
    out_ready[2] = 1'b0;
    send(2, 8'h55);
    drive(2, 8'h66);
    repeat (3) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'(out_data2), 32'h55);
      @(posedge clk); #1;
    end
    out_ready[2] = 1'b1;
    wait_accept(cyc);
    chk("bp_valid_kept", 32'(out_valid[2]), 32'd1);
    chk("bp_new_word", 32'(out_data2), 32'h66);
    idle(1);

    // Isolation: ch1 stalled, ch3 streams.
    out_ready = 4'b1101;
    send(1, 8'h11);
    send(3, 8'h22);
    send(3, 8'h33);
    idle(2);
    chk("iso_ch1_hold", 32'(out_data1), 32'h11);
    chk("iso_ch1_valid", 32'(out_valid[1]), 32'd1);
    out_ready = 4'b1111;
    idle(2);

    // Full throughput on ch0.
    total = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 8'(i));
      wait_accept(cyc);
      total += cyc;
    end
    chk("throughput_cycles", 32'(total), 32'd16);
    idle(2);

    // Reset mid-operation with ch0 and ch3 full and stalled.
    out_ready = 4'b0000;
    send(0, 8'hC0);
    send(3, 8'hC3);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_valid", 32'(out_valid), 32'd0);
    out_ready = 4'b1111;
    send(0, 8'h5A);
    chk("post_midreset_data", 32'(out_data0), 32'h5A);
    idle(2);

    // Randomized traffic with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 1500; i++) begin
      out_ready = 4'($urandom);
      if ($urandom_range(3) == 0) idle(1);
      else send(int'($urandom_range(3)), 8'($urandom));
    end
    rand_ready = 0;
    out_ready = 4'b1111;
    idle(3);
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
